edge_filter_3x3: RTL



---
 rtl/edge_filter_3x3.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/edge_filter_3x3.sv
// 3x3 Sobel/Scharr gradient-magnitude edge filter: column window, |Gx|+|Gy|, shift and saturate.
// Optional EDGE_FILTER_THRESHOLD_EN binarises the output against i_threshold.
module edge_filter_3x3 #(
  parameter int Y_DEPTH      = 8,
  parameter int SOBEL_SHIFT  = 2,
  parameter int SCHARR_SHIFT = 4
) (
  input  logic               i_pclk,
  input  logic               i_arst,
  input  logic               i_valid,
  input  logic               i_sol,
  input  logic               i_mode,
  input  logic [Y_DEPTH-1:0] i_pixel_r0,
  input  logic [Y_DEPTH-1:0] i_pixel_r1,
  input  logic [Y_DEPTH-1:0] i_pixel_r2,
`ifdef EDGE_FILTER_THRESHOLD_EN
  input  logic [Y_DEPTH-1:0] i_threshold,
`endif
  output logic [Y_DEPTH-1:0] o_pixel,
  output logic               o_valid
);

  localparam int GW = Y_DEPTH + 6;

  typedef logic [Y_DEPTH-1:0]   pix_t;
  typedef logic signed [GW-1:0] grad_t;

  function automatic grad_t px(input pix_t p);
    return $signed({6'd0, p});
  endfunction

  function automatic logic [GW-1:0] abs_g(input grad_t v);
    logic [GW-1:0] r;
    r = v[GW-1] ? $unsigned(-v) : $unsigned(v);
    return r;
  endfunction

  // ---------------- stage 0: window, fill counter, mode latch ----------------
  pix_t       col_in [3];
  pix_t       win_reg [3][3];  // [column: 0 newest, 1 centre, 2 oldest][row]
  logic [1:0] fill_cnt_reg;
  logic [1:0] fill_cnt_next;
  logic       mode_reg;
  logic       s0_valid_reg;

  assign col_in[0] = i_pixel_r0;
  assign col_in[1] = i_pixel_r1;
  assign col_in[2] = i_pixel_r2;

  always_comb begin
    fill_cnt_next = fill_cnt_reg;
    if (i_valid) begin
      if (i_sol)
        fill_cnt_next = 2'd1;
      else if (fill_cnt_reg != 2'd3)
        fill_cnt_next = fill_cnt_reg + 2'd1;
    end
  end

  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          win_reg[c][r] <= '0;
      fill_cnt_reg <= '0;
      mode_reg     <= 1'b0;
      s0_valid_reg <= 1'b0;
    end else begin
      fill_cnt_reg <= fill_cnt_next;
      s0_valid_reg <= i_valid && (fill_cnt_next == 2'd3);
      if (i_valid) begin
        for (int r = 0; r < 3; r++) begin
          win_reg[2][r] <= win_reg[1][r];
          win_reg[1][r] <= win_reg[0][r];
          win_reg[0][r] <= col_in[r];
        end
        if (i_sol)
          mode_reg <= i_mode;
      end
    end
  end

  // ---------------- stage 1: gradients ----------------
  // dx[gi]: row gi, newest minus oldest column; dy[gi]: column gi, bottom minus top row.
  grad_t dx [3];
  grad_t dy [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_diff
      assign dx[gi] = px(win_reg[0][gi]) - px(win_reg[2][gi]);
      assign dy[gi] = px(win_reg[gi][2]) - px(win_reg[gi][0]);
    end
  endgenerate

  grad_t ka;
  grad_t kb;
  grad_t gx_next;
  grad_t gy_next;
  grad_t gx_reg;
  grad_t gy_reg;
  logic  s1_valid_reg;
  logic  s1_mode_reg;

  // mode_reg still holds the line's kernel here even if a new line starts this edge.
  always_comb begin
    ka      = mode_reg ? GW'(3)  : GW'(1);
    kb      = mode_reg ? GW'(10) : GW'(2);
    gx_next = ka * dx[0] + kb * dx[1] + ka * dx[2];
    gy_next = ka * dy[0] + kb * dy[1] + ka * dy[2];
  end

  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      gx_reg       <= '0;
      gy_reg       <= '0;
      s1_valid_reg <= 1'b0;
      s1_mode_reg  <= 1'b0;
    end else begin
      s1_valid_reg <= s0_valid_reg;
      if (s0_valid_reg) begin
        gx_reg      <= gx_next;
        gy_reg      <= gy_next;
        s1_mode_reg <= mode_reg;
      end
    end
  end

  // ---------------- stage 2: magnitude ----------------
  logic [GW-1:0] mag_reg;
  logic          s2_valid_reg;
  logic          s2_mode_reg;

  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      mag_reg      <= '0;
      s2_valid_reg <= 1'b0;
      s2_mode_reg  <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        mag_reg     <= abs_g(gx_reg) + abs_g(gy_reg);
        s2_mode_reg <= s1_mode_reg;
      end
    end
  end

  // ---------------- stage 3: scale, saturate, output ----------------
  logic [GW-1:0] scaled;
  pix_t          sat_pix;
  pix_t          out_next;

  always_comb begin
    scaled  = s2_mode_reg ? (mag_reg >> SCHARR_SHIFT) : (mag_reg >> SOBEL_SHIFT);
    sat_pix = (|scaled[GW-1:Y_DEPTH]) ? '1 : scaled[Y_DEPTH-1:0];
`ifdef EDGE_FILTER_THRESHOLD_EN
    out_next = (sat_pix >= i_threshold) ? '1 : '0;
`else
    out_next = sat_pix;
`endif
  end

  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      o_pixel <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= s2_valid_reg;
      if (s2_valid_reg)
        o_pixel <= out_next;
    end
  end

endmodule
